// File: rtl/ttt_token_accumulator.sv
// rtl/ttt_token_accumulator.sv - per-processor good/bad token accumulator with threshold fire queue
// Optional: define TTT_ACC_SAT_FLAG_EN to add the sticky sat_flag output.
module ttt_token_accumulator #(
    parameter int NUM_PROCESSORS  = 10,
    parameter int NEW_TOKENS_BITS = 4,
    parameter int PROG_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 4,
    localparam int ID_W           = $clog2(NUM_PROCESSORS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ID_W-1:0]            target_id,
    input  logic [NEW_TOKENS_BITS-1:0] new_good_tokens,
    input  logic [NEW_TOKENS_BITS-1:0] new_bad_tokens,
    output logic                       fire_valid,
    input  logic                       fire_ready,
    output logic [ID_W-1:0]            fire_id,
    input  logic [2:0]                 instruction,
`ifdef TTT_ACC_SAT_FLAG_EN
    output logic                       sat_flag,
`endif
    input  logic [PROG_WIDTH-1:0]      prog_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = PROG_WIDTH + 1;
    localparam logic signed [PROG_WIDTH-1:0] MAX_V = {1'b0, {(PROG_WIDTH-1){1'b1}}};
    localparam logic signed [PROG_WIDTH-1:0] MIN_V = {1'b1, {(PROG_WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_SET_ADDR = 3'd1;
    localparam logic [2:0] OP_GOOD_THR = 3'd2;
    localparam logic [2:0] OP_BAD_THR  = 3'd3;
    localparam logic [2:0] OP_CLEAR    = 3'd4;

    logic signed [PROG_WIDTH-1:0] r_good     [NUM_PROCESSORS];
    logic signed [PROG_WIDTH-1:0] r_bad      [NUM_PROCESSORS];
    logic signed [PROG_WIDTH-1:0] r_good_thr [NUM_PROCESSORS];
    logic signed [PROG_WIDTH-1:0] r_bad_thr  [NUM_PROCESSORS];
    logic        [PROG_WIDTH-1:0] r_prog_addr;

    logic [ID_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic                         w_idle_op;
    logic                         w_full;
    logic                         w_accept;
    logic                         w_tgt_ok;
    logic [ID_W-1:0]              w_idx;
    logic                         w_prog_ok;
    logic [ID_W-1:0]              w_prog_idx;
    logic signed [SUM_W-1:0]      w_good_sum;
    logic signed [SUM_W-1:0]      w_bad_sum;
    logic signed [PROG_WIDTH-1:0] w_good_new;
    logic signed [PROG_WIDTH-1:0] w_bad_new;
    logic                         w_good_clamp;
    logic                         w_bad_clamp;
    logic                         w_fire;
    logic                         w_push;
    logic                         w_pop;

    // Programming opcodes block updates; reserved opcodes behave as NOP
    assign w_idle_op  = (instruction == OP_NOP) || (instruction > OP_CLEAR);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign in_ready   = w_idle_op && !w_full;
    assign w_accept   = in_valid && in_ready;

    // Out-of-range IDs are steered to entry 0 for the read but never written
    assign w_tgt_ok   = (32'(target_id) < NUM_PROCESSORS);
    assign w_idx      = w_tgt_ok ? target_id : '0;
    assign w_prog_ok  = (32'(r_prog_addr) < NUM_PROCESSORS);
    assign w_prog_idx = r_prog_addr[ID_W-1:0];

    // One extra bit of headroom so overflow shows up as a sign disagreement
    assign w_good_sum = {r_good[w_idx][PROG_WIDTH-1], r_good[w_idx]}
                      + {{(SUM_W-NEW_TOKENS_BITS){new_good_tokens[NEW_TOKENS_BITS-1]}}, new_good_tokens};
    assign w_bad_sum  = {r_bad[w_idx][PROG_WIDTH-1], r_bad[w_idx]}
                      + {{(SUM_W-NEW_TOKENS_BITS){new_bad_tokens[NEW_TOKENS_BITS-1]}}, new_bad_tokens};

    // Saturate both sums into the signed counter range
    always_comb begin
        w_good_new   = w_good_sum[PROG_WIDTH-1:0];
        w_bad_new    = w_bad_sum[PROG_WIDTH-1:0];
        w_good_clamp = 1'b0;
        w_bad_clamp  = 1'b0;
        if (w_good_sum[SUM_W-1] != w_good_sum[SUM_W-2]) begin
            w_good_clamp = 1'b1;
            w_good_new   = w_good_sum[SUM_W-1] ? MIN_V : MAX_V;
        end
        if (w_bad_sum[SUM_W-1] != w_bad_sum[SUM_W-2]) begin
            w_bad_clamp = 1'b1;
            w_bad_new   = w_bad_sum[SUM_W-1] ? MIN_V : MAX_V;
        end
    end

    assign w_fire = (w_good_new >= r_good_thr[w_idx]) && (w_bad_new < r_bad_thr[w_idx]);
    assign w_push = w_accept && w_tgt_ok && w_fire;
    assign w_pop  = fire_valid && fire_ready;

    assign fire_valid = (r_count != '0);
    assign fire_id    = fire_valid ? r_fifo[r_rd_ptr] : '0;

    // Programming, counter clear and per-beat accumulate/fire of the addressed processor
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prog_addr <= '0;
            for (int i = 0; i < NUM_PROCESSORS; i++) begin
                r_good[i]     <= '0;
                r_bad[i]      <= '0;
                r_good_thr[i] <= MAX_V;
                r_bad_thr[i]  <= MAX_V;
            end
        end else begin
            case (instruction)
                OP_SET_ADDR: r_prog_addr <= prog_data;
                OP_GOOD_THR: if (w_prog_ok) r_good_thr[w_prog_idx] <= prog_data;
                OP_BAD_THR:  if (w_prog_ok) r_bad_thr[w_prog_idx] <= prog_data;
                OP_CLEAR: begin
                    for (int i = 0; i < NUM_PROCESSORS; i++) begin
                        r_good[i] <= '0;
                        r_bad[i]  <= '0;
                    end
                end
                default: ;
            endcase
            if (w_accept && w_tgt_ok) begin
                r_good[w_idx] <= w_fire ? '0 : w_good_new;
                r_bad[w_idx]  <= w_fire ? '0 : w_bad_new;
            end
        end
    end

    // Fire queue: circular buffer with explicit occupancy count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_idx;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef TTT_ACC_SAT_FLAG_EN
    // Sticky record that some accepted update hit a clamp since the last clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag <= 1'b0;
        end else if (instruction == OP_CLEAR) begin
            sat_flag <= 1'b0;
        end else if (w_accept && w_tgt_ok && (w_good_clamp || w_bad_clamp)) begin
            sat_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ttt_token_accumulator.sv
// tb/tb_ttt_token_accumulator.sv - self-checking bench for ttt_token_accumulator
module tb_ttt_token_accumulator;

    localparam int NP = 10;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] target_id = '0;
    logic [3:0] new_good_tokens = '0;
    logic [3:0] new_bad_tokens = '0;
    logic       fire_valid;
    logic       fire_ready = 1'b0;
    logic [3:0] fire_id;
    logic [2:0] instruction = '0;
    logic [7:0] prog_data = '0;
`ifdef TTT_ACC_SAT_FLAG_EN
    logic       sat_flag;
`endif

    ttt_token_accumulator dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .target_id(target_id), .new_good_tokens(new_good_tokens),
        .new_bad_tokens(new_bad_tokens), .fire_valid(fire_valid),
        .fire_ready(fire_ready), .fire_id(fire_id), .instruction(instruction),
`ifdef TTT_ACC_SAT_FLAG_EN
        .sat_flag(sat_flag),
`endif
        .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int m_good [NP];
    int m_bad  [NP];
    int m_gthr [NP];
    int m_bthr [NP];
    int m_paddr;
    int m_q [$];
    bit m_sat;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int s8(int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int clamp8(int v, output bit c);
        c = 1'b0;
        if (v > 127) begin c = 1'b1; return 127; end
        if (v < -128) begin c = 1'b1; return -128; end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_good[i] = 0; m_bad[i] = 0; m_gthr[i] = 127; m_bthr[i] = 127;
        end
        m_paddr = 0;
        m_q.delete();
        m_sat = 1'b0;
    endtask

    // One clock: drive, check in_ready, clock, advance the model, check outputs
    task automatic cycle(int instr, int pdata, bit v, int t, int g, int b, bit fr);
        bit exp_rdy, cg, cb;
        int gs, bs;
        instruction     = instr[2:0];
        prog_data       = pdata[7:0];
        in_valid        = v;
        target_id       = t[3:0];
        new_good_tokens = g[3:0];
        new_bad_tokens  = b[3:0];
        fire_ready      = fr;
        #2;
        exp_rdy = ((instr == 0) || (instr >= 5)) && (m_q.size() < FD);
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        #1;
        if (fr && m_q.size() > 0) void'(m_q.pop_front());
        case (instr)
            1: m_paddr = pdata;
            2: if (m_paddr < NP) m_gthr[m_paddr] = s8(pdata);
            3: if (m_paddr < NP) m_bthr[m_paddr] = s8(pdata);
            4: begin
                for (int i = 0; i < NP; i++) begin m_good[i] = 0; m_bad[i] = 0; end
                m_sat = 1'b0;
            end
            default: ;
        endcase
        if (v && exp_rdy && t < NP) begin
            gs = clamp8(m_good[t] + g, cg);
            bs = clamp8(m_bad[t] + b, cb);
            if (cg || cb) m_sat = 1'b1;
            if (gs >= m_gthr[t] && bs < m_bthr[t]) begin
                m_q.push_back(t);
                m_good[t] = 0; m_bad[t] = 0;
            end else begin
                m_good[t] = gs; m_bad[t] = bs;
            end
        end
        chk("fire_valid", fire_valid, (m_q.size() > 0));
        chk("fire_id", fire_id, (m_q.size() > 0) ? m_q[0] : 0);
`ifdef TTT_ACC_SAT_FLAG_EN
        chk("sat_flag", sat_flag, m_sat);
`endif
    endtask

    task automatic beat(int t, int g, int b, bit fr);
        cycle(0, 0, 1'b1, t, g, b, fr);
    endtask

    task automatic idle(int n, bit fr);
        for (int i = 0; i < n; i++) cycle(0, 0, 1'b0, 0, 0, 0, fr);
    endtask

    task automatic prog(int addr, int gthr, int bthr);
        cycle(1, addr, 1'b0, 0, 0, 0, 1'b0);
        cycle(2, gthr, 1'b0, 0, 0, 0, 1'b0);
        cycle(3, bthr, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        int r;
        model_reset();
        #12;
        chk("reset_fire_valid", fire_valid, 1'b0);
        chk("reset_fire_id", fire_id, 4'd0);
        chk("reset_in_ready", in_ready, 1'b1);
        reset = 1'b0;

        // Basic fire
        prog(3, 5, 2);
        beat(3, 3, 0, 1'b0);
        chk("basic_no_fire_first", fire_valid, 1'b0);
        beat(3, 2, 0, 1'b0);
        chk("basic_fire_valid", fire_valid, 1'b1);
        chk("basic_fire_id", fire_id, 4'd3);
        beat(3, 4, 0, 1'b1);
        chk("basic_cleared_no_refire", fire_valid, 1'b0);

        // Inhibition
        cycle(4, 0, 1'b0, 0, 0, 0, 1'b0);
        beat(3, 0, 2, 1'b0);
        beat(3, 6, 0, 1'b0);
        chk("inhibit_no_fire", fire_valid, 1'b0);

        // Saturation
        cycle(4, 0, 1'b0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 19; i++) begin
            beat(0, 7, -8, 1'b0);
            if (i == 17) chk("sat_no_fire_beat18", fire_valid, 1'b0);
        end
        chk("sat_fire_valid", fire_valid, 1'b1);
        chk("sat_fire_id", fire_id, 4'd0);
`ifdef TTT_ACC_SAT_FLAG_EN
        chk("sat_flag_set", sat_flag, 1'b1);
`endif
        idle(1, 1'b1);

        // FIFO full / backpressure
        cycle(4, 0, 1'b0, 0, 0, 0, 1'b0);
        prog(1, 1, 127);
        prog(2, 1, 127);
        prog(4, 1, 127);
        prog(7, 1, 127);
        beat(1, 1, 0, 1'b0);
        beat(2, 1, 0, 1'b0);
        beat(4, 1, 0, 1'b0);
        beat(7, 1, 0, 1'b0);
        #2;
        chk("full_in_ready_low", in_ready, 1'b0);
        #1;
        beat(5, 1, 0, 1'b0);
        beat(5, 1, 0, 1'b1);
        chk("pop_order_second", fire_id, 4'd2);
        beat(5, 1, 0, 1'b1);
        chk("pop_order_third", fire_id, 4'd4);
        idle(1, 1'b1);
        chk("pop_order_fourth", fire_id, 4'd7);
        idle(1, 1'b1);
        chk("drained", fire_valid, 1'b0);

        // Programming priority and out-of-range target
        cycle(2, 127, 1'b1, 7, 1, 0, 1'b0);
        cycle(2, 127, 1'b1, 7, 1, 0, 1'b0);
        beat(12, 7, 7, 1'b0);
        chk("oor_no_fire", fire_valid, 1'b0);

        // Async reset with two queued fires
        cycle(4, 0, 1'b0, 0, 0, 0, 1'b0);
        beat(1, 1, 0, 1'b0);
        beat(2, 1, 0, 1'b0);
        chk("pre_reset_queued", fire_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_fire_valid", fire_valid, 1'b0);
        chk("async_reset_fire_id", fire_id, 4'd0);
        model_reset();
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        beat(3, 5, 0, 1'b0);
        chk("post_reset_default_thr", fire_valid, 1'b0);
        beat(1, 1, 0, 1'b1);
        chk("post_reset_thr1_restored", fire_valid, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4)
                cycle(1, $urandom_range(0, 11), 1'b0, 0, 0, 0, $urandom_range(0, 3) != 0);
            else if (r < 9)
                cycle(2, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20),
                      $urandom_range(0, 1), $urandom_range(0, 11), $urandom_range(0, 15) - 8,
                      $urandom_range(0, 15) - 8, $urandom_range(0, 3) != 0);
            else if (r < 13)
                cycle(3, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40),
                      1'b0, 0, 0, 0, $urandom_range(0, 3) != 0);
            else if (r < 14)
                cycle(4, 0, $urandom_range(0, 1), 0, 0, 0, $urandom_range(0, 1));
            else if (r < 17)
                cycle($urandom_range(5, 7), 0, $urandom_range(0, 1), $urandom_range(0, 11),
                      $urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8, $urandom_range(0, 1));
            else
                cycle(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 11),
                      $urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8,
                      $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
